// File: rtl/fifo_read_arbiter_pkg.sv
// Shared definitions for the FIFO read-port arbiter: FSM state encodings
// and requester index constants used by the arbiter and its RR picker.
package fifo_rd_arb_defs;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RD0   = 2'd1,
    S_BURST = 2'd2
  } state_t;

  localparam logic REQ_SINGLE = 1'b0;
  localparam logic REQ_BURST  = 1'b1;

endpackage

// File: rtl/fifo_read_arbiter_rr_arb2.sv
// Two-input round-robin picker. Remembers which requester was served last
// and, on a tie, favours the other one. last_srv resets to the burst side
// so the single-read requester wins the first tie after reset.
module rr_arb2
  import fifo_rd_arb_defs::*;
(
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic       i_update,
  input  logic       i_served,
  output logic       o_valid,
  output logic       o_grant
);

  logic r_last_srv;

  // Record the requester that just completed service.
  always_ff @(posedge clk) begin
    if (!i_rst_n) begin
      r_last_srv <= REQ_BURST;
    end else if (i_update) begin
      r_last_srv <= i_served;
    end
  end

  // Pick the lone requester, or the one not served last on a tie.
  always_comb begin
    o_valid = |i_req;
    o_grant = REQ_SINGLE;
    if (i_req == 2'b11) begin
      o_grant = ~r_last_srv;
    end else if (i_req[1]) begin
      o_grant = REQ_BURST;
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// FIFO read-port arbiter between a single-word reader (citaj) and a
// fixed-length burst reader (citajVise). Round-robin on ties, registered
// outputs, no preemption. Optional burst stall timeout is enabled with the
// macro FIFO_RD_ARB_TIMEOUT_EN.
// A burst whose requester drops req1 ends on that cycle without taking a
// further beat, so no word is pulled that nobody will consume.
module fifo_read_arbiter
  import fifo_rd_arb_defs::*;
#(
  parameter int BURST_LEN = 4,
  parameter int BCNT_W    = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic              clk,
  input  logic              rst_edge,
  input  logic              req0,
  input  logic              req1,
  input  logic              fifo_empty,
  output logic              citaj,
  output logic              citajVise,
  output logic              gnt0,
  output logic              gnt1,
  output logic              beat1,
  output logic              burst_done,
  output logic              burst_abort,
  output logic [BCNT_W-1:0] beat_cnt
);

  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BURST_LEN - 1);

  // Reject configurations the counters cannot represent.
  if (BURST_LEN < 1 || BURST_LEN > 15 || BURST_LEN >= (1 << BCNT_W) || TIMEOUT < 1) begin : g_param_check
    $error("fifo_read_arbiter: illegal BURST_LEN/BCNT_W/TIMEOUT");
  end

  state_t            r_state, w_state_next;
  logic [BCNT_W-1:0] r_bcnt, w_bcnt_next;

  logic w_citaj, w_vise, w_gnt0, w_gnt1, w_beat, w_done, w_abort;
  logic w_upd, w_served;
  logic w_arb_valid, w_arb_grant;
  logic w_stall_hit;

  logic              r_citaj, r_vise, r_gnt0, r_gnt1, r_beat, r_done, r_abort;
  logic [BCNT_W-1:0] r_beat_cnt_o;

  rr_arb2 u_rr (
    .clk      (clk),
    .i_rst_n  (rst_edge),
    .i_req    ({req1, req0}),
    .i_update (w_upd),
    .i_served (w_served),
    .o_valid  (w_arb_valid),
    .o_grant  (w_arb_grant)
  );

`ifdef FIFO_RD_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] r_stall;
  logic [STALL_W-1:0] w_stall_inc;
  logic               w_stalling;

  assign w_stalling  = (r_state == S_BURST) && req1 && fifo_empty;
  assign w_stall_inc = r_stall + 1'b1;
  assign w_stall_hit = w_stalling && (w_stall_inc == STALL_W'(TIMEOUT));

  // Count consecutive empty cycles of a live burst; any beat or exit clears it.
  always_ff @(posedge clk) begin
    if (!rst_edge) begin
      r_stall <= '0;
    end else if (w_stalling && !w_stall_hit) begin
      r_stall <= w_stall_inc;
    end else begin
      r_stall <= '0;
    end
  end
`else
  assign w_stall_hit = 1'b0;
`endif

  // State, beat counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst_edge) begin
      r_state      <= S_IDLE;
      r_bcnt       <= '0;
      r_citaj      <= 1'b0;
      r_vise       <= 1'b0;
      r_gnt0       <= 1'b0;
      r_gnt1       <= 1'b0;
      r_beat       <= 1'b0;
      r_done       <= 1'b0;
      r_abort      <= 1'b0;
      r_beat_cnt_o <= '0;
    end else begin
      r_state      <= w_state_next;
      r_bcnt       <= w_bcnt_next;
      r_citaj      <= w_citaj;
      r_vise       <= w_vise;
      r_gnt0       <= w_gnt0;
      r_gnt1       <= w_gnt1;
      r_beat       <= w_beat;
      r_done       <= w_done;
      r_abort      <= w_abort;
      r_beat_cnt_o <= r_bcnt;
    end
  end

  // Next state and strobe decode; strobes only fire when the FIFO has data.
  always_comb begin
    w_state_next = r_state;
    w_bcnt_next  = r_bcnt;
    w_citaj      = 1'b0;
    w_vise       = 1'b0;
    w_gnt0       = 1'b0;
    w_gnt1       = 1'b0;
    w_beat       = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    w_upd        = 1'b0;
    w_served     = REQ_SINGLE;
    case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_state_next = (w_arb_grant == REQ_BURST) ? S_BURST : S_RD0;
        end
      end
      S_RD0: begin
        if (!fifo_empty) begin
          w_citaj      = 1'b1;
          w_gnt0       = 1'b1;
          w_upd        = 1'b1;
          w_served     = REQ_SINGLE;
          w_state_next = S_IDLE;
        end
      end
      S_BURST: begin
        w_gnt1 = 1'b1;
        if (!req1 || w_stall_hit) begin
          w_abort      = 1'b1;
          w_bcnt_next  = '0;
          w_upd        = 1'b1;
          w_served     = REQ_BURST;
          w_state_next = S_IDLE;
        end else if (!fifo_empty) begin
          w_vise = 1'b1;
          w_beat = 1'b1;
          if (r_bcnt == LAST_BEAT) begin
            w_done       = 1'b1;
            w_bcnt_next  = '0;
            w_upd        = 1'b1;
            w_served     = REQ_BURST;
            w_state_next = S_IDLE;
          end else begin
            w_bcnt_next = r_bcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_bcnt_next  = '0;
      end
    endcase
  end

  assign citaj       = r_citaj;
  assign citajVise   = r_vise;
  assign gnt0        = r_gnt0;
  assign gnt1        = r_gnt1;
  assign beat1       = r_beat;
  assign burst_done  = r_done;
  assign burst_abort = r_abort;
  assign beat_cnt    = r_beat_cnt_o;

endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Self-checking bench for fifo_read_arbiter: a cycle-level behavioural
// model compared against the DUT every cycle, plus directed scenarios with
// literal expectations (latency, burst sequence, alternation, stall, abort,
// timeout, reset mid-burst).
module tb_fifo_read_arbiter;

  localparam int BURST_LEN = 4;
  localparam int BCNT_W    = 4;
  localparam int TIMEOUT   = 8;

  logic clk = 1'b0;
  logic rst_edge, req0, req1, fifo_empty;
  logic citaj, citajVise, gnt0, gnt1, beat1, burst_done, burst_abort;
  logic [BCNT_W-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_read_arbiter #(.BURST_LEN(BURST_LEN), .BCNT_W(BCNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_edge(rst_edge), .req0(req0), .req1(req1), .fifo_empty(fifo_empty),
    .citaj(citaj), .citajVise(citajVise), .gnt0(gnt0), .gnt1(gnt1), .beat1(beat1),
    .burst_done(burst_done), .burst_abort(burst_abort), .beat_cnt(beat_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // owner: 0 = port free, 1 = single reader holds it, 2 = burst reader holds it
  int owner, beats_taken, empty_run, last_served;
  bit m_valid = 1'b0;
  logic e_citaj, e_vise, e_gnt0, e_gnt1, e_beat, e_done, e_abort;
  logic [BCNT_W-1:0] e_bcnt;

  always @(posedge clk) begin
    m_valid = 1'b1;
    {e_citaj, e_vise, e_gnt0, e_gnt1, e_beat, e_done, e_abort} = '0;
    e_bcnt = '0;
    if (!rst_edge) begin
      owner = 0; beats_taken = 0; empty_run = 0; last_served = 1;
    end else begin
      e_bcnt = BCNT_W'(beats_taken);
      if (owner == 0) begin
        if (req0 && (!req1 || last_served == 1)) owner = 1;
        else if (req1) owner = 2;
      end else if (owner == 1) begin
        if (!fifo_empty) begin
          e_citaj = 1; e_gnt0 = 1; last_served = 0; owner = 0;
        end
      end else begin
        e_gnt1 = 1;
        if (!req1) begin
          e_abort = 1; beats_taken = 0; empty_run = 0; last_served = 1; owner = 0;
        end else if (!fifo_empty) begin
          e_vise = 1; e_beat = 1; empty_run = 0;
          beats_taken = beats_taken + 1;
          if (beats_taken == BURST_LEN) begin
            e_done = 1; beats_taken = 0; last_served = 1; owner = 0;
          end
        end else begin
          empty_run = empty_run + 1;
`ifdef FIFO_RD_ARB_TIMEOUT_EN
          if (empty_run == TIMEOUT) begin
            e_abort = 1; beats_taken = 0; empty_run = 0; last_served = 1; owner = 0;
          end
`endif
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cycle", {citaj, citajVise, gnt0, gnt1, beat1, burst_done, burst_abort, beat_cnt},
                     {e_citaj, e_vise, e_gnt0, e_gnt1, e_beat, e_done, e_abort, e_bcnt});
      check("excl", {31'd0, citaj & citajVise}, 32'd0);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_edge = 1'b0;
    repeat (2) wait_cycle();
    rst_edge = 1'b1;
  endtask

  task automatic run_burst(input int stall_after, input int stall_len, input int abort_after,
                           output int nb, output int nhold, output bit done_seen,
                           output bit abort_seen, output logic [15:0] seq);
    int left;
    bit stalled;
    nb = 0; nhold = 0; done_seen = 0; abort_seen = 0; seq = '0; left = 0; stalled = 0;
    req1 = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      wait_cycle();
      if (citajVise) begin
        if (nb < 4) seq[nb*4 +: 4] = beat_cnt;
        nb++;
      end
      if (gnt1 && !citajVise && !burst_abort && beat_cnt == BCNT_W'(stall_after)) nhold++;
      if (burst_done) begin done_seen = 1; req1 = 1'b0; break; end
      if (burst_abort) begin abort_seen = 1; req1 = 1'b0; break; end
      if (nb == abort_after) begin req1 = 1'b0; req0 = 1'b1; end
      if (stall_len > 0 && !stalled && nb == stall_after) begin
        fifo_empty = 1'b1; left = stall_len; stalled = 1;
      end else if (left > 0) begin
        left--;
        if (left == 0) fifo_empty = 1'b0;
      end
    end
  endtask

  initial begin
    int nb, nhold, cnt;
    bit done_seen, abort_seen, got;
    logic [15:0] seq;
    logic [7:0] ev;
    int nev;

    rst_edge = 1'b0; req0 = 1'b0; req1 = 1'b0; fifo_empty = 1'b0;
    repeat (3) wait_cycle();
    check("rst_outputs", {24'd0, citaj, citajVise, gnt0, gnt1, beat1, burst_done, burst_abort, beat_cnt}, 32'd0);
    rst_edge = 1'b1;
    wait_cycle();

    // Single read latency: sampled at one edge, strobe visible after the next.
    req0 = 1'b1;
    wait_cycle();
    check("t1_no_strobe_yet", {31'd0, citaj}, 32'd0);
    wait_cycle();
    check("t1_strobe", {30'd0, citaj, gnt0}, 32'd3);
    req0 = 1'b0;
    wait_cycle();
    check("t1_one_cycle", {30'd0, citaj, gnt0}, 32'd0);
    $display("txn single_read done");
    wait_cycle();

    // Plain 4-beat burst.
    run_burst(-1, 0, -1, nb, nhold, done_seen, abort_seen, seq);
    check("t2_beats", nb, 4);
    check("t2_seq", {16'd0, seq}, 32'h3210);
    check("t2_done", {31'd0, done_seen}, 32'd1);
    wait_cycle();
    check("t2_idle", {30'd0, gnt1, citajVise}, 32'd0);
    $display("txn burst beats=%0d seq=%h", nb, seq);

    // Burst with 3 empty cycles after the second beat.
    run_burst(2, 3, -1, nb, nhold, done_seen, abort_seen, seq);
    check("t4_beats", nb, 4);
    check("t4_hold_cycles", nhold, 3);
    check("t4_seq", {16'd0, seq}, 32'h3210);
    check("t4_done", {31'd0, done_seen}, 32'd1);
    $display("txn stalled_burst beats=%0d hold=%0d", nb, nhold);
    wait_cycle();

    // Burst abandoned after its first beat; pending single read follows.
    run_burst(-1, 0, 1, nb, nhold, done_seen, abort_seen, seq);
    check("t5_abort", {30'd0, abort_seen, done_seen}, 32'd2);
    check("t5_beats", nb, 1);
    wait_cycle();
    check("t5_cnt_clear", {27'd0, gnt1, beat_cnt}, 32'd0);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      if (citajVise) break;
      if (gnt0) begin got = 1; break; end
      wait_cycle();
    end
    check("t5_single_next", {31'd0, got}, 32'd1);
    req0 = 1'b0;
    $display("txn aborted_burst beats=%0d then single", nb);
    wait_cycle();

    // Both requesters held: single, burst, single, burst from reset.
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    ev = '0; nev = 0;
    for (int i = 0; i < 40 && nev < 4; i++) begin
      wait_cycle();
      if (gnt0) begin ev = {ev[5:0], 2'd1}; nev++; end
      if (burst_done) begin ev = {ev[5:0], 2'd2}; nev++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t3_events", nev, 4);
    check("t3_order", {24'd0, ev}, 32'h66);
    $display("txn alternation order=%h", ev);
    repeat (2) wait_cycle();

    // Burst into an empty FIFO.
    fifo_empty = 1'b1;
    req1 = 1'b1;
    cnt = 0; abort_seen = 0;
    for (int i = 0; i < 21; i++) begin
      wait_cycle();
      if (gnt1 && !citajVise) cnt++;
      if (burst_abort) begin abort_seen = 1; req1 = 1'b0; break; end
    end
`ifdef FIFO_RD_ARB_TIMEOUT_EN
    check("t6_timeout_abort", {31'd0, abort_seen}, 32'd1);
    check("t6_stall_cycles", cnt, 8);
`else
    check("t6_no_abort", {31'd0, abort_seen}, 32'd0);
    check("t6_stall_cycles", cnt, 20);
    req1 = 1'b0;
    wait_cycle();
    check("t6_drop_abort", {31'd0, burst_abort}, 32'd1);
`endif
    $display("txn empty_burst stall=%0d abort=%0d", cnt, abort_seen);
    fifo_empty = 1'b0;
    repeat (2) wait_cycle();

    // Reset in the middle of a burst: no done or abort, all outputs cleared.
    req1 = 1'b1;
    repeat (3) wait_cycle();
    rst_edge = 1'b0;
    wait_cycle();
    check("t7_rst_mid", {24'd0, citaj, citajVise, gnt0, gnt1, beat1, burst_done, burst_abort, beat_cnt}, 32'd0);
    req1 = 1'b0;
    rst_edge = 1'b1;
    repeat (2) wait_cycle();
    check("t7_after", {26'd0, burst_done, burst_abort, beat_cnt}, 32'd0);
    $display("txn reset_mid_burst");

    repeat (2) wait_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
